uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
UART transmit framer that sits directly downstream of parity_gen.
- Accepts a parallel data word through a valid/ready handshake.
- Presents the word to parity_gen, consumes the registered parity bit it returns, and serialises a start, data (LSB first), optional parity, and stop frame on tx_out.
- One bit is transmitted per baud_tick period. baud_tick comes from the shared baud-rate prescaler.

Parameters:
DATA_WIDTH, 8, number of data bits per frame. Must match parity_gen data_width. Legal range is 5 to 9.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
p_data  input  DATA_WIDTH  word to transmit
data_valid  input  1  p_data valid; transfer occurs when data_valid and data_ready are both high on a clk edge
data_ready  output  1  holding register empty; can accept a word
par_en  input  1  parity enable, sampled together with p_data on accept
baud_tick  input  1  one-clk strobe marking each bit boundary
par_data  output  DATA_WIDTH  frame word driven to parity_gen p_data
par_bit  input  1  registered parity from parity_gen (even/odd choice is made there through par_typ)
tx_out  output  1  serial line, idle high
busy  output  1  high when a frame is in flight or a word is pending

Behaviour:
Reset values (rst low, asynchronous):
- tx_out=1, data_ready=1, busy=0, par_data=0.
- State=IDLE, bit counter=0, pending flag cleared, holding register=0.

Holding stage:
- On accept (data_valid && data_ready), latch p_data and par_en into the holding register and set pending.
- data_ready = ~pending (registered).
- Accept may occur on any clk edge, independent of baud_tick.
- While pending=1, data_valid is ignored and the holding contents are not overwritten.

FSM states: IDLE, START, DATA, PARITY, STOP.
- Every transition and every tx_out change happens only on a clk edge with baud_tick=1. Each bit therefore lasts exactly one tick period.
- IDLE: tx_out=1. On a tick with pending=1:
  - tx_out<=0, state<=START.
  - Copy the holding register into the shift register and par_data; latch par_en.
  - Clear pending. data_ready rises the next cycle.
- START: on tick, tx_out<=shift[0], counter<=0, state<=DATA.
- DATA: on tick:
  - If counter<DATA_WIDTH-1: counter++, tx_out<=next data bit (LSB first).
  - Otherwise, if the latched par_en=1: tx_out<=par_bit, state<=PARITY.
  - Otherwise: tx_out<=1, state<=STOP.
- PARITY: on tick, tx_out<=1, state<=STOP.
- STOP: on tick:
  - If pending=1, go back to back: tx_out<=0, state<=START, with the same load/clear actions as IDLE.
  - Otherwise: tx_out<=1, state<=IDLE.

Parity timing:
- par_data is stable for the whole frame.
- parity_gen returns par_bit one clk after par_data changes. par_bit is sampled at least DATA_WIDTH ticks later, so no extra latency handling is needed.

Other rules:
- busy = (state != IDLE) || pending.
- baud_tick is at most one clk in every 2. Ticks are ignored in IDLE when pending=0.
- A new accept during a frame (into an empty holding register) does not disturb the current frame.
- par_en changing mid-frame has no effect on the current frame.
- Frame length is 1 + DATA_WIDTH + par_en + 1 ticks.
- Reset asserted mid-frame aborts immediately: tx_out=1, and the pending word is lost.

Test Plan:
- Reset then idle with ticks every 16 clks -> tx_out=1, busy=0, data_ready=1 throughout.
- Send 8'hA5, par_en=1, parity_gen even -> tx_out per tick: 0,1,0,1,0,0,1,0,1,0(parity),1. 11 ticks, then IDLE, busy=0.
- Send 8'hA5, par_en=1, parity_gen odd -> parity bit=1. Send 8'h00 with par_en=0 -> 0, eight 0s, 1 (10 ticks, no parity slot).
- Send 8'h3C, then 8'hC3 while the first is in DATA -> data_ready drops. Second frame's start bit immediately follows the first stop bit, with no idle bit. Both frames are correct.
- Hold data_valid high with a new word while pending=1 -> no overwrite. The second word is accepted only after data_ready returns high.
- Assert rst during the 4th data bit of 8'hFF -> tx_out=1 and busy=0 immediately. The next accepted 8'h81 transmits a clean full frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer: one-word holding register feeding a start/data/parity/stop
// serialiser that advances one bit per baud_tick; parity comes back from parity_gen.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  par_en,
    input  logic                  baud_tick,
    output logic [DATA_WIDTH-1:0] par_data,
    input  logic                  par_bit,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state, state_nxt;

    logic [DATA_WIDTH-1:0] hold_data, hold_data_nxt;
    logic                  hold_par_en, hold_par_en_nxt;
    logic                  pending, pending_nxt;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic                  par_en_lat, par_en_lat_nxt;
    logic [DATA_WIDTH-1:0] par_data_reg, par_data_nxt;
    logic                  tx_reg, tx_nxt;
    logic                  accept;
    logic                  load;

    assign accept     = data_valid && !pending;
    assign data_ready = ~pending;
    assign busy       = (state != IDLE) || pending;
    assign tx_out     = tx_reg;
    assign par_data   = par_data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers; the line idles high and the pending word is dropped on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data    <= '0;
            hold_par_en  <= 1'b0;
            pending      <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            par_en_lat   <= 1'b0;
            par_data_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            hold_data    <= hold_data_nxt;
            hold_par_en  <= hold_par_en_nxt;
            pending      <= pending_nxt;
            shift_reg    <= shift_nxt;
            bit_cnt      <= bit_cnt_nxt;
            par_en_lat   <= par_en_lat_nxt;
            par_data_reg <= par_data_nxt;
            tx_reg       <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        shift_nxt       = shift_reg;
        bit_cnt_nxt     = bit_cnt;
        par_en_lat_nxt  = par_en_lat;
        par_data_nxt    = par_data_reg;
        tx_nxt          = tx_reg;
        load            = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (baud_tick && pending) begin
                    load      = 1'b1;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_nxt      = shift_reg[0];
                    shift_nxt   = shift_reg >> 1;
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt < LAST_BIT) begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        tx_nxt      = shift_reg[0];
                        shift_nxt   = shift_reg >> 1;
                    end else if (par_en_lat) begin
                        tx_nxt    = par_bit;
                        state_nxt = PARITY;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (pending) begin
                        // Back-to-back: the next start bit directly replaces the idle bit.
                        load      = 1'b1;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase

        // par_data stays frozen for the whole frame so parity_gen's answer is settled by the parity slot.
        if (load) begin
            shift_nxt      = hold_data;
            par_data_nxt   = hold_data;
            par_en_lat_nxt = hold_par_en;
        end
    end

    // Holding stage; accept and load never coincide since one needs pending low, the other high.
    always_comb begin
        hold_data_nxt   = hold_data;
        hold_par_en_nxt = hold_par_en;
        pending_nxt     = pending;
        if (load) begin
            pending_nxt = 1'b0;
        end else if (accept) begin
            hold_data_nxt   = p_data;
            hold_par_en_nxt = par_en;
            pending_nxt     = 1'b1;
        end
    end

endmodule
